// File: rtl/ms53l_uart_rx_if.sv
// Byte-side bundle of the MS53L UART receiver.
// master drives strobes/data, slave is the frame parser.
interface ms53l_uart_rx_if;
   logic       rx_data_en;
   logic [7:0] rx_data;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx_data_en,
      output rx_data,
      output frame_err,
      output busy
   );

   modport slave (
      input rx_data_en,
      input rx_data,
      input frame_err,
      input busy
   );
endinterface

// File: rtl/ms53l_uart_rx.sv
// MS53L 8N1 UART byte receiver with mid-bit sampling.
// Define MS53L_RX_MAJORITY_EN for 2-of-3 majority sampling.
module ms53l_uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uart_rx,
   ms53l_uart_rx_if.master rx
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   localparam logic [CW-1:0] CPB_T  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_T = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [7:0]    shift;
   logic [7:0]    shift_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_nxt;
   logic [7:0]    data_q;
   logic [7:0]    data_nxt;
   logic          en_q;
   logic          en_nxt;
   logic          ferr_q;
   logic          ferr_nxt;
   logic          sync1;
   logic          rx_sync;
   logic          samp;
   logic          at_half;
   logic          at_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         sync1   <= uart_rx;
         rx_sync <= sync1;
      end
   end

`ifdef MS53L_RX_MAJORITY_EN
   // hist[0] is rx_sync one cycle back, hist[1] two cycles back
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= 2'b11;
      end else begin
         hist <= {hist[0], rx_sync};
      end
   end

   assign samp = (hist[1] & hist[0]) |
                 (hist[1] & rx_sync) |
                 (hist[0] & rx_sync);
`else
   assign samp = rx_sync;
`endif

   assign at_half = (cnt == HALF_T);
   assign at_full = (cnt == CPB_T);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      shift_nxt = shift;
      bit_nxt   = bit_idx;
      data_nxt  = data_q;
      en_nxt    = 1'b0;
      ferr_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (!rx_sync) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (at_half) begin
               cnt_nxt = '0;
               if (!samp) begin
                  state_nxt = S_DATA;
                  bit_nxt   = 3'd0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (at_full) begin
               cnt_nxt   = '0;
               shift_nxt = {samp, shift[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (at_full) begin
               cnt_nxt = '0;
               if (samp) begin
                  data_nxt  = shift;
                  en_nxt    = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // a held-low line or break must end before re-arming
            if (rx_sync) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shift   <= 8'h00;
         bit_idx <= 3'd0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         shift   <= shift_nxt;
         bit_idx <= bit_nxt;
         data_q  <= data_nxt;
         en_q    <= en_nxt;
         ferr_q  <= ferr_nxt;
      end
   end

   assign rx.rx_data_en = en_q;
   assign rx.rx_data    = data_q;
   assign rx.frame_err  = ferr_q;
   assign rx.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_ms53l_uart_rx.sv
// Directed bench for ms53l_uart_rx (CPB = 300, HALF = 150).
// Expected values follow the cycle timing of the receiver contract.
module tb_ms53l_uart_rx;
   localparam int CLK_FREQ = 30_000_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic uart_rx = 1'b1;

   ms53l_uart_rx_if rx_if ();

   ms53l_uart_rx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .uart_rx(uart_rx),
      .rx     (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] got_q[$];
   int         en_cnt      = 0;
   int         fe_cnt      = 0;
   int         viol        = 0;
   int         last_en_cyc = 0;
   int         start_cyc   = 0;
   logic       prev_pulse  = 1'b0;

   always @(negedge clk) begin
      if (rx_if.rx_data_en) begin
         got_q.push_back(rx_if.rx_data);
         en_cnt      <= en_cnt + 1;
         last_en_cyc <= cyc;
      end
      if (rx_if.frame_err) fe_cnt <= fe_cnt + 1;
      if ((rx_if.rx_data_en && rx_if.frame_err) ||
          (prev_pulse && (rx_if.rx_data_en || rx_if.frame_err)))
         viol <= viol + 1;
      prev_pulse <= rx_if.rx_data_en | rx_if.frame_err;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      uart_rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      start_cyc = cyc;
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   logic [7:0] frame [10];
   logic [7:0] exp6;
   int e0;
   int f0;

   initial begin
      frame = '{8'h55, 8'h0B, 8'h00, 8'h01, 8'h00,
                8'h00, 8'h05, 8'h02, 8'h01, 8'hF4};
`ifdef MS53L_RX_MAJORITY_EN
      exp6 = 8'h00;
`else
      exp6 = 8'h04;
`endif
      // reset state
      rst = 1'b1;
      hold(1'b1, 3);
      chk("rst_en", rx_if.rx_data_en, 0);
      chk("rst_ferr", rx_if.frame_err, 0);
      chk("rst_busy", rx_if.busy, 0);
      chk("rst_data", rx_if.rx_data, 8'h00);
      rst = 1'b0;
      hold(1'b1, 5);

      // single byte and strobe latency
      e0 = en_cnt;
      f0 = fe_cnt;
      send(8'h55, 1'b1);
      hold(1'b1, CPB);
      chk("t1_count", en_cnt - e0, 1);
      chk("t1_data", rx_if.rx_data, 8'h55);
      // rx_sync first reads 0 two edges after the line falls
      chk("t1_latency", last_en_cyc - start_cyc,
          2 + HALF + 9 * CPB + 1);
      chk("t1_ferr", fe_cnt - f0, 0);

      // stop bit low, line held low
      e0 = en_cnt;
      f0 = fe_cnt;
      send(8'hA5, 1'b0);
      hold(1'b0, 2000);
      chk("t4_ferr", fe_cnt - f0, 1);
      chk("t4_en", en_cnt - e0, 0);
      chk("t4_data_kept", rx_if.rx_data, 8'h55);
      chk("t4_busy_wait", rx_if.busy, 1);
      hold(1'b1, 10);
      chk("t4_busy_rel", rx_if.busy, 0);
      hold(1'b1, CPB);
      send(8'h3C, 1'b1);
      hold(1'b1, CPB);
      chk("t4_next_data", rx_if.rx_data, 8'h3C);
      chk("t4_next_en", en_cnt - e0, 1);

      // back-to-back distance frame
      got_q.delete();
      f0 = fe_cnt;
      for (int i = 0; i < 10; i++) send(frame[i], 1'b1);
      hold(1'b1, CPB);
      chk("t2_count", got_q.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < got_q.size())
            chk($sformatf("t2_byte%0d", i), got_q[i], frame[i]);
      end
      chk("t2_ferr", fe_cnt - f0, 0);

      // short low pulse while idle
      e0 = en_cnt;
      f0 = fe_cnt;
      hold(1'b0, 100);
      chk("t3_busy_start", rx_if.busy, 1);
      hold(1'b1, HALF + 3 - 100);
      chk("t3_busy_back", rx_if.busy, 0);
      chk("t3_no_en", en_cnt - e0, 0);
      hold(1'b1, CPB);
      send(8'hA5, 1'b1);
      hold(1'b1, CPB);
      chk("t3_data", rx_if.rx_data, 8'hA5);
      chk("t3_en", en_cnt - e0, 1);
      chk("t3_ferr", fe_cnt - f0, 0);

      // reset during data bit 4 of 0xFF
      e0 = en_cnt;
      f0 = fe_cnt;
      hold(1'b0, CPB);
      hold(1'b1, 4 * CPB + HALF);
      rst = 1'b1;
      hold(1'b1, 1);
      chk("t5_rst_en", rx_if.rx_data_en, 0);
      chk("t5_rst_ferr", rx_if.frame_err, 0);
      chk("t5_rst_busy", rx_if.busy, 0);
      chk("t5_rst_data", rx_if.rx_data, 8'h00);
      rst = 1'b0;
      hold(1'b1, 4 * CPB);
      chk("t5_no_en", en_cnt - e0, 0);
      chk("t5_no_ferr", fe_cnt - f0, 0);
      send(8'h3C, 1'b1);
      hold(1'b1, CPB);
      chk("t5_data", rx_if.rx_data, 8'h3C);
      chk("t5_en", en_cnt - e0, 1);

      // 0x00 with one-cycle high glitch on the bit-2 sample
      e0 = en_cnt;
      f0 = fe_cnt;
      hold(1'b0, 3 * CPB + HALF);
      hold(1'b1, 1);
      hold(1'b0, CPB - HALF - 1);
      hold(1'b0, 5 * CPB);
      hold(1'b1, CPB);
      hold(1'b1, CPB);
      chk("t6_data", rx_if.rx_data, exp6);
      chk("t6_en", en_cnt - e0, 1);
      chk("t6_ferr", fe_cnt - f0, 0);

      chk("pulse_rules", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
